// File: rtl/divu_arbiter_pkg.sv
// Shared types and the round-robin pick helper for the divider arbiter.
package divu_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // First set bit of valid at or after ptr, wrapping modulo n; ptr if none set.
    function automatic int rr_pick(input logic [31:0] valid, input int ptr, input int n);
        int idx;
        rr_pick = ptr;
        for (int i = n - 1; i >= 0; i--) begin
            idx = (ptr + i) % n;
            if (valid[idx[4:0]]) begin
                rr_pick = idx;
            end
        end
    endfunction

endpackage

// File: rtl/divu_arbiter_divu.sv
// Iterative restoring unsigned fixed-point divider: val = (a << FBITS) / b.
module divu #(
    parameter int WIDTH = 8,
    parameter int FBITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] val,
    output logic             dbz,
    output logic             ovf
);
    localparam int ITER = WIDTH + FBITS;
    localparam int CW   = $clog2(ITER + 1);

    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] bq;
    logic [ITER-1:0]  dvd;
    logic [ITER-1:0]  quo;
    logic [CW-1:0]    cnt;
    logic             ovf_seen;

    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             ge;
    logic [WIDTH-1:0] rem_nx;
    logic [ITER-1:0]  quo_nx;
    logic             ovf_nx;

    always_comb begin
        trial  = {rem, dvd[ITER-1]};
        diff   = trial - {1'b0, bq};
        ge     = (trial >= {1'b0, bq});
        rem_nx = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_nx = {quo[ITER-2:0], ge};
        // Quotient bits above WIDTH-1 come out in the first FBITS iterations.
        ovf_nx = ovf_seen | (ge & (cnt >= CW'(WIDTH)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            val      <= '0;
            dbz      <= 1'b0;
            ovf      <= 1'b0;
            rem      <= '0;
            bq       <= '0;
            dvd      <= '0;
            quo      <= '0;
            cnt      <= '0;
            ovf_seen <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                dbz <= 1'b0;
                ovf <= 1'b0;
                if (b == '0) begin
                    done <= 1'b1;
                    dbz  <= 1'b1;
                    val  <= '0;
                end else begin
                    busy     <= 1'b1;
                    cnt      <= CW'(ITER - 1);
                    rem      <= '0;
                    bq       <= b;
                    dvd      <= {a, {FBITS{1'b0}}};
                    quo      <= '0;
                    ovf_seen <= 1'b0;
                end
            end else if (busy) begin
                rem      <= rem_nx;
                dvd      <= {dvd[ITER-2:0], 1'b0};
                quo      <= quo_nx;
                ovf_seen <= ovf_nx;
                if (cnt == CW'(FBITS) && ovf_nx) begin
                    // Abort point is iteration WIDTH-1, which keeps overflow latency fixed.
                    busy <= 1'b0;
                    done <= 1'b1;
                    ovf  <= 1'b1;
                    val  <= '0;
                end else if (cnt == '0) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    val  <= quo_nx[WIDTH-1:0];
                end else begin
                    cnt <= cnt - CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/divu_arbiter.sv
// Round-robin scheduler sharing one divu between NREQ requesters.
//   state | meaning
//   IDLE  | arbitrate, accept one request
//   START | pulse divu.start with latched operands
//   WAIT  | divider running, capture result on done
//   RESP  | hold response for owner until rsp_ready[owner]
module divu_arbiter
    import divu_arbiter_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int FBITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]      rsp_val,
    output logic                  rsp_dbz,
    output logic                  rsp_ovf,
    output logic                  busy
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t           state;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    owner;
    logic [PW-1:0]    winner;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             div_rst;

    logic             div_start;
    logic             div_busy;
    logic             div_done;
    logic [WIDTH-1:0] div_val;
    logic             div_dbz;
    logic             div_ovf;

    always_comb begin
        winner    = PW'(rr_pick(32'(req_valid), int'(ptr), NREQ));
        req_ready = '0;
        if (state == IDLE && !div_rst && (|req_valid)) begin
            req_ready[winner] = 1'b1;
        end
        rsp_valid = '0;
        if (state == RESP) begin
            rsp_valid[owner] = 1'b1;
        end
    end

    assign busy      = (state != IDLE);
    assign div_start = (state == START) && !div_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            owner   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rsp_val <= '0;
            rsp_dbz <= 1'b0;
            rsp_ovf <= 1'b0;
            div_rst <= 1'b1;
        end else begin
            div_rst <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req_ready) begin
                        a_q   <= req_a[winner*WIDTH +: WIDTH];
                        b_q   <= req_b[winner*WIDTH +: WIDTH];
                        owner <= winner;
                        ptr   <= (winner == PW'(NREQ - 1)) ? '0 : winner + PW'(1);
                        state <= START;
                    end
                end
                START: state <= WAIT;
                WAIT: begin
                    if (div_done) begin
                        rsp_val <= (div_dbz || div_ovf) ? '0 : div_val;
                        rsp_dbz <= div_dbz;
                        rsp_ovf <= div_ovf;
                        state   <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready[owner]) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    divu #(
        .WIDTH (WIDTH),
        .FBITS (FBITS)
    ) u_divu (
        .clk   (clk),
        .rst   (div_rst),
        .start (div_start),
        .a     (a_q),
        .b     (b_q),
        .busy  (div_busy),
        .done  (div_done),
        .val   (div_val),
        .dbz   (div_dbz),
        .ovf   (div_ovf)
    );

endmodule

// File: tb/tb_divu_arbiter.sv
// Scoreboard bench for divu_arbiter: issuer model pushes expected responses, monitor pops and checks.
module tb_divu_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int FBITS = 4;
    localparam int ITER  = WIDTH + FBITS;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a = '0;
    logic [NREQ*WIDTH-1:0] req_b = '0;
    logic [NREQ-1:0]       rsp_valid;
    logic [NREQ-1:0]       rsp_ready = '1;
    logic [WIDTH-1:0]      rsp_val;
    logic                  rsp_dbz;
    logic                  rsp_ovf;
    logic                  busy;

    divu_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .FBITS(FBITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_val   (rsp_val),
        .rsp_dbz   (rsp_dbz),
        .rsp_ovf   (rsp_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         owner;
        logic [7:0] val;
        logic       dbz;
        logic       ovf;
        int         due;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    bit   m_idle = 1'b1;
    int   m_avail = 0;
    int   m_ptr = 0;
    bit   first_seen = 1'b0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference: fixed-point quotient by plain arithmetic, latency from the result class.
    function automatic exp_t model(input int k, input int a, input int b, input int t);
        exp_t e;
        int   quo;
        e.owner = k;
        e.dbz = 1'b0;
        e.ovf = 1'b0;
        e.val = 8'h00;
        if (b == 0) begin
            e.dbz = 1'b1;
            e.due = t + 3;
        end else begin
            quo = (a * (1 << FBITS)) / b;
            if (quo >= (1 << WIDTH)) begin
                e.ovf = 1'b1;
                e.due = t + WIDTH + 3;
            end else begin
                e.val = quo[7:0];
                e.due = t + ITER + 3;
            end
        end
        return e;
    endfunction

    // Issuer: expected grant from the round-robin rule; pushes the expected response on handshake.
    always @(negedge clk) begin
        logic [NREQ-1:0] exp_rdy;
        int w;
        bit found;
        if (!rst_n) begin
            q.delete();
            m_idle  = 1'b1;
            m_avail = cyc + 2;
            m_ptr   = 0;
        end else begin
            exp_rdy = '0;
            found = 1'b0;
            w = 0;
            if (m_idle && cyc >= m_avail) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (!found && req_valid[(m_ptr + i) % NREQ]) begin
                        w = (m_ptr + i) % NREQ;
                        found = 1'b1;
                    end
                end
            end
            if (found) exp_rdy[w] = 1'b1;
            check("req_ready", 32'(req_ready), 32'(exp_rdy));
            check("busy", 32'(busy), 32'(!m_idle));
            if (found) begin
                q.push_back(model(w, int'(req_a[w*WIDTH +: WIDTH]), int'(req_b[w*WIDTH +: WIDTH]), cyc));
                m_idle = 1'b0;
                m_ptr  = (w + 1) % NREQ;
            end
        end
    end

    // Monitor: compares presented responses against the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            first_seen = 1'b0;
        end else if (q.size() == 0) begin
            check("rsp_valid_idle", 32'(rsp_valid), 32'd0);
        end else begin
            e = q[0];
            if (rsp_valid != '0) begin
                if (!first_seen) begin
                    check("rsp_latency", cyc, e.due);
                    first_seen = 1'b1;
                end
                check("rsp_valid", 32'(rsp_valid), 32'(1) << e.owner);
                check("rsp_val", 32'(rsp_val), 32'(e.val));
                check("rsp_dbz", 32'(rsp_dbz), 32'(e.dbz));
                check("rsp_ovf", 32'(rsp_ovf), 32'(e.ovf));
                if (rsp_ready[e.owner]) begin
                    void'(q.pop_front());
                    first_seen = 1'b0;
                    m_idle  = 1'b1;
                    m_avail = cyc + 1;
                end
            end else if (cyc >= e.due) begin
                check("rsp_missing", 32'(rsp_valid), 32'(1) << e.owner);
                void'(q.pop_front());
                first_seen = 1'b0;
                m_idle  = 1'b1;
                m_avail = cyc + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs_zero();
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_val", 32'(rsp_val), 32'd0);
        check("rst_rsp_dbz", 32'(rsp_dbz), 32'd0);
        check("rst_rsp_ovf", 32'(rsp_ovf), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_grant(input int k);
        bit ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (req_ready[k]) ok = 1'b1;
            tick();
        end
        if (!ok) check("grant_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            if (q.size() == 0 && m_idle) ok = 1'b1;
            else tick();
        end
        if (!ok) check("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_req(input int k, input logic [7:0] a, input logic [7:0] b);
        req_a[k*WIDTH +: WIDTH] = a;
        req_b[k*WIDTH +: WIDTH] = b;
        req_valid = '0;
        req_valid[k] = 1'b1;
        wait_grant(k);
        req_valid = '0;
    endtask

    task automatic rand_operands();
        int sel;
        for (int k = 0; k < NREQ; k++) begin
            req_a[k*WIDTH +: WIDTH] = 8'($urandom_range(0, 255));
            sel = $urandom_range(0, 9);
            if (sel == 0)      req_b[k*WIDTH +: WIDTH] = 8'h00;
            else if (sel <= 3) req_b[k*WIDTH +: WIDTH] = 8'($urandom_range(1, 3));
            else               req_b[k*WIDTH +: WIDTH] = 8'($urandom_range(1, 255));
        end
    endtask

    initial begin
        repeat (3) tick();
        check_outputs_zero();
        rst_n = 1'b1;
        tick();

        do_req(2, 8'h30, 8'h20);
        wait_idle(40);

        // All requesters valid across reset: grants must rotate from 0.
        req_valid = '1;
        rsp_ready = '1;
        do_reset();
        for (int i = 0; i < 85; i++) begin
            rand_operands();
            tick();
        end
        req_valid = '0;
        wait_idle(40);

        do_req(1, 8'h55, 8'h00);
        wait_idle(20);
        do_req(3, 8'hF0, 8'h01);
        wait_idle(30);

        // Consumer stall with another requester waiting; foreign rsp_ready bits set.
        rsp_ready = 4'b1110;
        do_req(0, 8'h40, 8'h20);
        req_a[3*WIDTH +: WIDTH] = 8'h10;
        req_b[3*WIDTH +: WIDTH] = 8'h30;
        req_valid = 4'b1000;
        for (int i = 0; i < 30 && rsp_valid == '0; i++) tick();
        repeat (20) tick();
        rsp_ready = '1;
        wait_grant(3);
        req_valid = '0;
        wait_idle(40);

        // Reset while the divider is iterating; a fresh request must then complete normally.
        do_req(2, 8'h7F, 8'h05);
        repeat (5) tick();
        do_reset();
        repeat (3) tick();
        do_req(1, 8'h21, 8'h13);
        wait_idle(40);

        for (int i = 0; i < 400; i++) begin
            req_valid = 4'($urandom_range(0, 15));
            rsp_ready = 4'($urandom_range(0, 15));
            rand_operands();
            tick();
        end
        req_valid = '0;
        rsp_ready = '1;
        wait_idle(40);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
